cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Miss-handling controller that refills one 16-byte cache block (8 x 16-bit words) from main memory through the shared memory arbiter port. One instance sits beside each of the I-cache and D-cache. On a miss it issues the 8 word reads, streams the returned words into the cache data array, and writes the tag array on the final word. It stalls its requester via fsm_busy for the whole fill.

Parameters:
WORDS, 8, words per cache block; power of two, 2..16.
ADDR_W, 16, byte address width.
DATA_W, 16, memory word width.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
miss_detected  in  1  cache miss for miss_address; sampled only in IDLE.
miss_address  in  ADDR_W  byte address of the missing access.
mem_grant  in  1  arbiter accepted the current read address this cycle.
mem_data_valid  in  1  memory returns one read word this cycle.
mem_data_in  in  DATA_W  returned word.
mem_req  out  1  read request to the arbiter.
mem_addr  out  ADDR_W  byte address of the current read request.
fsm_busy  out  1  fill in progress; requester stalls.
write_data_array  out  1  write fill_data into the data array at word_offset.
word_offset  out  log2(WORDS)  word index within the block for the current write.
fill_data  out  DATA_W  word to write; equals mem_data_in.
write_tag_array  out  1  one-cycle pulse: write the tag and set the valid bit for the block.
protocol_err  out  1  sticky; set when mem_data_valid arrives with no outstanding read.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, FILL. Reset puts the FSM in IDLE, clears issue_cnt, ret_cnt and protocol_err, and clears base_addr to 0. All outputs are 0 while rst is high and in the cycle after it.
- IDLE: if miss_detected is high at the clock edge, latch base_addr = miss_address with bits [log2(WORDS*2)-1:0] cleared, clear both counters, and go to FILL. Otherwise stay in IDLE.
- fsm_busy = (state==FILL). It is combinational and is not asserted in the same cycle as miss_detected.
- mem_req = FILL & (issue_cnt < WORDS).
- mem_addr = base_addr + 2*issue_cnt, truncated to ADDR_W bits. It is 0 when mem_req is low.
- issue_cnt increments on (mem_req & mem_grant). The address is held stable while the grant is low.
- Return path: in FILL, mem_data_valid & (issue_cnt > ret_cnt) gives write_data_array=1, word_offset=ret_cnt, fill_data=mem_data_in, and ret_cnt increments at the edge. Words are written strictly in issue order.
- Last word: mem_data_valid with ret_cnt==WORDS-1 asserts write_tag_array in the same cycle as the final data write, and the next state is IDLE.
- Reads are pipelined. Issue and return may happen in the same cycle, and both counters update independently.
- Latency to memory is arbitrary but in-order. Minimum fill time is WORDS cycles after the first return.
- mem_data_valid in IDLE, or in FILL with issue_cnt==ret_cnt, gives no writes and sets protocol_err. protocol_err clears only on rst.
- miss_detected while in FILL is ignored. A new miss is accepted from IDLE no earlier than the cycle after write_tag_array.
- rst mid-fill aborts to IDLE with no further writes. The partially written block stays tag-invalid because no tag write occurred.
- Counters are log2(WORDS)+1 bits wide; they neither wrap nor saturate within a fill.

Test Plan:
- Basic fill: set miss_address=0x1236, keep mem_grant=1, and use a 4-cycle latency memory model returning addr^0xA5A5. Required: mem_addr = 0x1230, 0x1232 ... 0x123E on 8 consecutive cycles; 8 writes with offsets 0..7 and the matching data; write_tag_array on the 8th write only; fsm_busy drops the next cycle.
- Grant stall: drop mem_grant for 3 cycles after the 2nd issue. Required: mem_addr holds at 0x1234; no address is skipped or duplicated; the fill still completes with 8 writes.
- Same-cycle issue and return: run the 1-cycle latency model. Required: issue_cnt and ret_cnt both advance each cycle; the fill completes in 9 cycles from entering FILL.
- Spurious valid: pulse mem_data_valid in IDLE. Required: no write_data_array; protocol_err=1 and held until rst.
- Miss during fill and back-to-back misses: assert miss_detected throughout a fill for 0x0040, then change the address to 0x0080. Required: the second fill starts only after the first tag write, and its first mem_addr is 0x0080.
- Reset mid-fill: assert rst after 3 returned words. Required: the next cycle shows all outputs 0 and state IDLE; write_tag_array never pulses; a subsequent miss fills correctly from offset 0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache block refill controller: issues WORDS pipelined word reads for a missing
// block, streams the returned words into the data array and writes the tag on the last word.
module cache_fill_fsm #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    localparam int OFF_W = $clog2(WORDS),
    localparam int CNT_W = OFF_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_grant,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              fsm_busy,
    output logic              write_data_array,
    output logic [OFF_W-1:0]  word_offset,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array,
    output logic              protocol_err
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * WORDS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic [ADDR_W-1:0] base_addr_q, base_addr_d;
    logic              protocol_err_q, protocol_err_d;

    logic in_fill;
    logic req_int;
    logic ret_ok;
    logic last_ret;

    assign in_fill  = (state_q == FILL);
    assign req_int  = in_fill && (issue_cnt_q < CNT_W'(WORDS));
    // A return is only legal while at least one read is outstanding.
    assign ret_ok   = in_fill && mem_data_valid && (issue_cnt_q > ret_cnt_q);
    assign last_ret = ret_ok && (ret_cnt_q == CNT_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            issue_cnt_q    <= '0;
            ret_cnt_q      <= '0;
            base_addr_q    <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            issue_cnt_q    <= issue_cnt_d;
            ret_cnt_q      <= ret_cnt_d;
            base_addr_q    <= base_addr_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        issue_cnt_d    = issue_cnt_q;
        ret_cnt_d      = ret_cnt_q;
        base_addr_d    = base_addr_q;
        protocol_err_d = protocol_err_q | (mem_data_valid & ~ret_ok);
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    base_addr_d = miss_address & BLOCK_MASK;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // Issue and return sides advance independently, possibly in the same cycle.
                if (req_int && mem_grant) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (ret_ok) begin
                    ret_cnt_d = ret_cnt_q + CNT_W'(1);
                end
                if (last_ret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req          = 1'b0;
        mem_addr         = '0;
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        word_offset      = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;
        protocol_err     = 1'b0;
        // Everything is forced quiet while reset is held, whatever the state flops hold.
        if (!rst) begin
            fsm_busy         = in_fill;
            mem_req          = req_int;
            write_data_array = ret_ok;
            write_tag_array  = last_ret;
            protocol_err     = protocol_err_q;
            if (req_int) begin
                mem_addr = base_addr_q + (ADDR_W'(issue_cnt_q) << 1);
            end
            if (ret_ok) begin
                word_offset = ret_cnt_q[OFF_W-1:0];
                fill_data   = mem_data_in;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with an in-order, fixed-latency memory model
// returning addr^0xA5A5 and a scoreboard of expected issue addresses and writes.
module tb_cache_fill_fsm;

    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        mem_grant = 1'b0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data_in = 16'h0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        fsm_busy;
    logic        write_data_array;
    logic [2:0]  word_offset;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic        protocol_err;

    cache_fill_fsm #(.WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .mem_grant(mem_grant), .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .fsm_busy(fsm_busy),
        .write_data_array(write_data_array), .word_offset(word_offset), .fill_data(fill_data),
        .write_tag_array(write_tag_array), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Per-cycle stimulus intent, applied at the next falling edge.
    logic        g_rst = 1'b1;
    logic        g_miss = 1'b0;
    logic [15:0] g_addr = 16'h0;
    logic        g_grant = 1'b1;
    logic        g_spur = 1'b0;

    int          cycnum = 0;
    int          lat = 1;
    int          rq_cyc[$];
    logic [15:0] rq_addr[$];

    logic [15:0] exp_base;
    logic [15:0] exp_issue;
    int          exp_off;
    int          issues, writes, tags;
    int          first_issue_cyc, last_issue_cyc;
    logic [15:0] first_issue_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rst = g_rst;
        miss_detected = g_miss;
        miss_address = g_addr;
        mem_grant = g_grant;
        mem_data_valid = 1'b0;
        mem_data_in = 16'h0;
        if (g_rst) begin
            rq_cyc.delete();
            rq_addr.delete();
        end else if (g_spur) begin
            mem_data_valid = 1'b1;
            mem_data_in = 16'hDEAD;
        end else if (rq_cyc.size() != 0 && rq_cyc[0] == cycnum) begin
            mem_data_valid = 1'b1;
            mem_data_in = rq_addr[0] ^ 16'hA5A5;
            void'(rq_cyc.pop_front());
            void'(rq_addr.pop_front());
        end
        #1;
        if (mem_req && mem_grant) begin
            chk("issue_addr", mem_addr, exp_issue);
            if (issues == 0) begin
                first_issue_cyc = cycnum;
                first_issue_addr = mem_addr;
            end
            last_issue_cyc = cycnum;
            rq_cyc.push_back(cycnum + lat);
            rq_addr.push_back(mem_addr);
            exp_issue = exp_issue + 16'd2;
            issues++;
        end else if (mem_req) begin
            chk("stall_addr_hold", mem_addr, exp_issue);
        end
        if (write_data_array) begin
            chk("word_offset", word_offset, exp_off);
            chk("fill_data", fill_data, (exp_base + 16'(2 * exp_off)) ^ 16'hA5A5);
            chk("tag_on_last_only", write_tag_array, exp_off == WORDS - 1);
            exp_off++;
            writes++;
        end
        if (write_tag_array) begin
            chk("tag_with_write", write_data_array, 1);
            tags++;
        end
        cycnum++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_busy"}, fsm_busy, 0);
        chk({tag, "_wr"}, write_data_array, 0);
        chk({tag, "_off"}, word_offset, 0);
        chk({tag, "_data"}, fill_data, 0);
        chk({tag, "_tag"}, write_tag_array, 0);
        chk({tag, "_perr"}, protocol_err, 0);
    endtask

    // Miss cycle: the block is not yet busy while the miss is being presented.
    task automatic start_fill(input logic [15:0] a, input int lt, input logic keep_miss);
        lat = lt;
        exp_base = {a[15:4], 4'h0};
        exp_issue = exp_base;
        exp_off = 0;
        issues = 0;
        writes = 0;
        tags = 0;
        g_miss = 1'b1;
        g_addr = a;
        g_grant = 1'b1;
        cyc();
        chk("busy_in_miss_cycle", fsm_busy, 0);
        g_miss = keep_miss;
    endtask

    task automatic run_until_tag(input int stall_at, input int stall_n, output int n);
        int st;
        n = 0;
        st = 0;
        while (tags == 0 && n < 60) begin
            g_grant = !(issues == stall_at && st < stall_n);
            if (!g_grant) st++;
            cyc();
            n++;
        end
        g_grant = 1'b1;
        chk("tag_seen", tags, 1);
        chk("issue_count", issues, WORDS);
        chk("write_count", writes, WORDS);
    endtask

    initial begin
        int n;

        // Reset state, and the cycle after reset is released.
        g_rst = 1'b1;
        cyc();
        chk_zero("rst_hold");
        cyc();
        g_rst = 1'b0;
        cyc();
        chk_zero("post_rst");

        // Basic fill with 4-cycle latency memory.
        start_fill(16'h1236, 4, 1'b0);
        run_until_tag(-1, 0, n);
        chk("basic_fill_cycles", n, 12);
        chk("basic_first_addr", first_issue_addr, 16'h1230);
        chk("basic_issue_consecutive", last_issue_cyc - first_issue_cyc, 7);
        cyc();
        chk("basic_busy_drop", fsm_busy, 0);
        chk("basic_req_drop", mem_req, 0);

        // Grant withheld for 3 cycles after the second issue.
        start_fill(16'h1236, 4, 1'b0);
        run_until_tag(2, 3, n);
        chk("stall_fill_cycles", n, 15);
        cyc();
        chk("stall_busy_drop", fsm_busy, 0);

        // 1-cycle latency: issue and return overlap every cycle.
        start_fill(16'h5A5A, 1, 1'b0);
        run_until_tag(-1, 0, n);
        chk("lat1_fill_cycles", n, 9);
        chk("lat1_issue_consecutive", last_issue_cyc - first_issue_cyc, 7);
        cyc();

        // Miss held through a fill, then a back-to-back miss to another block.
        start_fill(16'h0040, 1, 1'b1);
        run_until_tag(-1, 0, n);
        chk("hold_miss_fill_cycles", n, 9);
        start_fill(16'h0080, 1, 1'b0);
        run_until_tag(-1, 0, n);
        chk("b2b_first_addr", first_issue_addr, 16'h0080);
        chk("b2b_fill_cycles", n, 9);
        cyc();

        // Spurious return in IDLE.
        writes = 0;
        g_spur = 1'b1;
        cyc();
        g_spur = 1'b0;
        chk("spur_no_write", write_data_array, 0);
        chk("spur_perr_not_yet", protocol_err, 0);
        cyc();
        chk("spur_perr_set", protocol_err, 1);
        cyc();
        cyc();
        chk("spur_perr_sticky", protocol_err, 1);
        chk("spur_write_count", writes, 0);

        // Reset after three returned words aborts the fill.
        start_fill(16'h2222, 1, 1'b0);
        n = 0;
        while (writes < 3 && n < 40) begin
            cyc();
            n++;
        end
        chk("abort_writes_before_rst", writes, 3);
        g_rst = 1'b1;
        cyc();
        chk_zero("abort_rst_hi");
        g_rst = 1'b0;
        cyc();
        chk_zero("abort_after");
        chk("abort_no_tag", tags, 0);
        chk("abort_writes_total", writes, 3);

        // A fresh fill after the abort starts at offset 0.
        start_fill(16'h3456, 4, 1'b0);
        run_until_tag(-1, 0, n);
        chk("refill_first_addr", first_issue_addr, 16'h3450);
        chk("refill_cycles", n, 12);
        cyc();
        chk("refill_busy_drop", fsm_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
